// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer.
// Main entry M feeds MEM and the bypass tap; skid entry S absorbs one stall.
module ex_mem_stage #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [DATA_W-1:0]  alu_c_i,
   input  logic [RADDR_W-1:0] rd_i,
   input  logic               rf_we_i,
   input  logic               mem_re_i,
   input  logic               mem_we_i,
   input  logic [DATA_W-1:0]  store_data_i,
   input  logic [DATA_W-1:0]  pc_i,
   input  logic               flush_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [DATA_W-1:0]  out_c_o,
   output logic [RADDR_W-1:0] out_rd_o,
   output logic               out_rf_we_o,
   output logic               out_mem_re_o,
   output logic               out_mem_we_o,
   output logic [DATA_W-1:0]  out_store_data_o,
   output logic [DATA_W-1:0]  out_pc_o,
   output logic               fwd_valid_o,
   output logic [RADDR_W-1:0] fwd_rd_o,
   output logic [DATA_W-1:0]  fwd_data_o
);

   typedef struct packed {
      logic [DATA_W-1:0]  c;
      logic [RADDR_W-1:0] rd;
      logic               rf_we;
      logic               mem_re;
      logic               mem_we;
      logic [DATA_W-1:0]  sd;
      logic [DATA_W-1:0]  pc;
   } ent_t;

   // bit0 = M valid, bit1 = S valid, so handshake flags are raw flops
   typedef enum logic [1:0] {
      ST_E = 2'b00,
      ST_M = 2'b01,
      ST_F = 2'b11
   } st_t;

   st_t  state_q, state_d;
   ent_t m_q, m_d;
   ent_t s_q, s_d;
   ent_t in_ent;
   logic accept;
   logic emit;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_E;
         m_q     <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         s_q     <= s_d;
      end
   end

   always_comb begin
      in_ent        = '0;
      in_ent.c      = alu_c_i;
      in_ent.rd     = rd_i;
      in_ent.rf_we  = rf_we_i & (rd_i != '0);
      in_ent.mem_re = mem_re_i;
      in_ent.mem_we = mem_we_i;
      in_ent.sd     = store_data_i;
      in_ent.pc     = pc_i;
   end

   always_comb begin
      in_ready_o  = ~state_q[1];
      out_valid_o = state_q[0];
      accept      = in_valid_i & in_ready_o;
      emit        = out_valid_o & out_ready_i;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_E: if (accept) state_d = ST_M;
         ST_M: begin
            if (accept && !emit)      state_d = ST_F;
            else if (!accept && emit) state_d = ST_E;
         end
         ST_F: if (emit) state_d = ST_M;
         default: state_d = ST_E;
      endcase
      if (flush_i) state_d = ST_E;
   end

   always_comb begin
      m_d = m_q;
      s_d = s_q;
      if (!flush_i) begin
         unique case (state_q)
            ST_E: if (accept) m_d = in_ent;
            ST_M: begin
               if (accept && emit) m_d = in_ent;
               else if (accept)    s_d = in_ent;
            end
            ST_F: if (emit) m_d = s_q;
            default: ;
         endcase
      end
   end

   always_comb begin
      out_c_o          = m_q.c;
      out_rd_o         = m_q.rd;
      out_rf_we_o      = m_q.rf_we;
      out_mem_re_o     = m_q.mem_re;
      out_mem_we_o     = m_q.mem_we;
      out_store_data_o = m_q.sd;
      out_pc_o         = m_q.pc;
      fwd_valid_o      = state_q[0] & m_q.rf_we & ~m_q.mem_re;
      fwd_rd_o         = m_q.rd;
      fwd_data_o       = m_q.c;
   end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: queue model plus directed scenarios.
module tb_ex_mem_stage;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [31:0] alu_c = 0;
   logic [4:0]  rd = 0;
   logic        rf_we = 0;
   logic        mem_re = 0;
   logic        mem_we = 0;
   logic [31:0] sd = 0;
   logic [31:0] pc = 0;
   logic        flush = 0;
   logic        out_valid;
   logic        out_ready = 0;
   logic [31:0] out_c;
   logic [4:0]  out_rd;
   logic        out_rf_we;
   logic        out_mem_re;
   logic        out_mem_we;
   logic [31:0] out_sd;
   logic [31:0] out_pc;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   always #5 clk = ~clk;

   ex_mem_stage dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .alu_c_i(alu_c), .rd_i(rd), .rf_we_i(rf_we),
      .mem_re_i(mem_re), .mem_we_i(mem_we),
      .store_data_i(sd), .pc_i(pc), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_c_o(out_c), .out_rd_o(out_rd),
      .out_rf_we_o(out_rf_we), .out_mem_re_o(out_mem_re),
      .out_mem_we_o(out_mem_we), .out_store_data_o(out_sd),
      .out_pc_o(out_pc), .fwd_valid_o(fwd_valid),
      .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data)
   );

   typedef struct {
      logic [31:0] c;
      logic [4:0]  rd;
      logic        we;
      logic        re;
      logic        mwe;
      logic [31:0] sd;
      logic [31:0] pc;
   } bun_t;

   int errors = 0;
   int checks = 0;
   bun_t q[$];
   logic [31:0] log_q[$];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: a FIFO of depth two; capacity alone decides in_ready.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         bit acc, emi;
         bun_t b;
         acc = in_valid && q.size() < 2;
         emi = out_ready && q.size() > 0;
         if (emi) void'(q.pop_front());
         if (acc) begin
            b.c = alu_c; b.rd = rd; b.we = rf_we && rd != 0;
            b.re = mem_re; b.mwe = mem_we; b.sd = sd; b.pc = pc;
            q.push_back(b);
         end
      end
   end

   always @(negedge clk) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
         chk("out_c", out_c, q[0].c);
         chk("out_rd", out_rd, q[0].rd);
         chk("out_rf_we", out_rf_we, q[0].we);
         chk("out_mem_re", out_mem_re, q[0].re);
         chk("out_mem_we", out_mem_we, q[0].mwe);
         chk("out_sd", out_sd, q[0].sd);
         chk("out_pc", out_pc, q[0].pc);
         chk("fwd_valid", fwd_valid, q[0].we && !q[0].re);
         chk("fwd_rd", fwd_rd, q[0].rd);
         chk("fwd_data", fwd_data, q[0].c);
      end else begin
         chk("fwd_valid_idle", fwd_valid, 0);
      end
      if (rst_n && out_valid && out_ready && !flush) log_q.push_back(out_c);
   end

   task automatic offer(logic [31:0] c, logic [4:0] r, logic w,
                        logic re, logic mw);
      in_valid = 1; alu_c = c; rd = r; rf_we = w;
      mem_re = re; mem_we = mw; sd = ~c; pc = 32'h1000 + c * 4;
   endtask

   task automatic wait_acc();
      bit ok;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #2;
         if (ok) return;
      end
      chk("accept_timeout", 1, 0);
   endtask

   task automatic push(logic [31:0] c, logic [4:0] r, logic w);
      offer(c, r, w, 0, 0);
      wait_acc();
   endtask

   task automatic idle(int n);
      in_valid = 0;
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int base;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_c", out_c, 0);
      chk("rst_fwd_valid", fwd_valid, 0);
      @(posedge clk); #2;
      rst_n = 1;

      // pass-through
      out_ready = 1;
      push(32'hF800_0000, 5, 1);
      in_valid = 0;
      chk("pt_valid", out_valid, 1);
      chk("pt_c", out_c, 32'hF800_0000);
      chk("pt_fwd_valid", fwd_valid, 1);
      chk("pt_fwd_rd", fwd_rd, 5);
      @(posedge clk); #2;
      chk("pt_valid_after", out_valid, 0);

      // backpressure and skid
      log_q.delete();
      out_ready = 0;
      push(1, 1, 1);
      push(2, 2, 1);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_head_a", out_c, 1);
      offer(3, 3, 1, 0, 0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk("bp_still_full", in_ready, 0);
      out_ready = 1;
      wait_acc();
      idle(4);
      chk("bp_count", log_q.size(), 3);
      for (int i = 0; i < 3 && i < log_q.size(); i++)
         chk("bp_order", log_q[i], i + 1);

      // streaming
      log_q.delete();
      for (int i = 0; i < 8; i++) begin
         offer(i, 5'(i + 8), 1, 0, 0);
         chk("st_in_ready", in_ready, 1);
         wait_acc();
      end
      idle(3);
      chk("st_count", log_q.size(), 8);
      for (int i = 0; i < 8 && i < log_q.size(); i++)
         chk("st_order", log_q[i], i);

      // flush in F
      out_ready = 0;
      push(32'hA, 1, 1);
      push(32'hB, 2, 1);
      base = log_q.size();
      offer(32'hD, 3, 1, 0, 0);
      flush = 1;
      @(posedge clk); #2;
      flush = 0;
      in_valid = 0;
      chk("fl_valid", out_valid, 0);
      chk("fl_in_ready", in_ready, 1);
      out_ready = 1;
      idle(4);
      chk("fl_no_emit", log_q.size(), base);

      // x0 and load
      push(32'h55, 0, 1);
      in_valid = 0;
      chk("x0_valid", out_valid, 1);
      chk("x0_rf_we", out_rf_we, 0);
      chk("x0_fwd", fwd_valid, 0);
      offer(32'h77, 7, 1, 1, 0);
      wait_acc();
      in_valid = 0;
      chk("ld_valid", out_valid, 1);
      chk("ld_mem_re", out_mem_re, 1);
      chk("ld_fwd", fwd_valid, 0);
      idle(2);

      // async reset in F
      out_ready = 0;
      push(32'h11, 4, 1);
      push(32'h22, 6, 1);
      in_valid = 0;
      chk("ar_full", in_ready, 0);
      #1 rst_n = 0;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_in_ready", in_ready, 1);
      chk("ar_c", out_c, 0);
      chk("ar_rd", out_rd, 0);
      chk("ar_pc", out_pc, 0);
      chk("ar_sd", out_sd, 0);
      chk("ar_fwd", fwd_valid, 0);
      @(posedge clk); #2;
      rst_n = 1;
      out_ready = 1;
      push(32'h99, 9, 1);
      in_valid = 0;
      chk("post_rst_c", out_c, 32'h99);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
